// File: rtl/uart_rx_buffer_if.sv
// uart_rx_buffer_if
// Groups the receiver-side capture signals and the consumer-side FIFO
// drain signals of uart_rx_buffer into one bundle.
//   slave  : the buffer itself (takes rx_*, out_take, clear_overrun;
//            drives rx_ack, out_*, count, full, overrun)
//   master : the surrounding receiver/consumer logic (or a testbench)
interface uart_rx_buffer_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          rx_data;
    logic                rx_ready;
    logic                rx_ack;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_take;
    logic [DEPTH_LOG2:0] count;
    logic                full;
    logic                overrun;
    logic                clear_overrun;

    modport slave (
        input  rx_data, rx_ready, out_take, clear_overrun,
        output rx_ack, out_data, out_valid, count, full, overrun
    );

    modport master (
        output rx_data, rx_ready, out_take, clear_overrun,
        input  rx_ack, out_data, out_valid, count, full, overrun
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
// Captures each byte the UART receiver flags with its level-held ready
// flag, acknowledges it through the receiver's reset_ready input, and
// queues it in a 2^DEPTH_LOG2-entry first-word-fall-through FIFO.
// A sticky overrun flag records bytes lost to a full FIFO.
// Ports:
//   clk   : system clock (same as the receiver)
//   reset : asynchronous, active-high; clears all state except memory
//   bus   : uart_rx_buffer_if.slave (rx_data/rx_ready/rx_ack capture side,
//           out_data/out_valid/out_take drain side, count/full/overrun
//           status, clear_overrun)
//
// state  | meaning
// S_IDLE | waiting for rx_ready; rx_ack low
// S_ACK  | byte taken, rx_ack high until the receiver drops rx_ready
module uart_rx_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_rx_buffer_if.slave         bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    ack_q, ack_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    overrun_q, overrun_d;
    logic [7:0]              mem_q [DEPTH];

    logic capture;
    logic pop;
    logic push;
    logic drop;
    logic is_full;

    assign is_full = (count_q == CNT_FULL);
    assign pop     = (count_q != '0) && bus.out_take;
    assign capture = (state_q == S_IDLE) && bus.rx_ready;
    // A full FIFO still accepts the byte when the head leaves on the same edge.
    assign push    = capture && (!is_full || pop);
    assign drop    = capture && is_full && !pop;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.rx_ready) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                end
            end
            S_ACK: begin
                if (!bus.rx_ready) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A drop on the same edge as a clear must leave the flag set.
        if (drop)
            overrun_d = 1'b1;
        else if (bus.clear_overrun)
            overrun_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ack_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers make stale
    // contents unreachable.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.rx_data;
    end

    assign bus.rx_ack    = ack_q;
    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.out_valid = (count_q != '0);
    assign bus.count     = count_q;
    assign bus.full      = is_full;
    assign bus.overrun   = overrun_q;
endmodule
